// File: rtl/vec_pkg.sv
// Shared vector-path types and sizes for the MEM gather stage.
package vec_pkg;

   localparam int unsigned LANES  = 16;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned IDX_W  = $clog2(LANES);

   typedef logic [DATA_W-1:0] word_t;
   typedef word_t [LANES-1:0] vec_t;
   typedef logic [REG_W-1:0]  reg_idx_t;

endpackage

// File: rtl/lane_counter.sv
// Lane pointer for the gather buffer: advances on each enabled word, wraps after the
// last lane, and returns to lane 0 whenever the read stream pauses.
module lane_counter #(
   parameter int unsigned Lanes = 16,
   parameter int unsigned IdxW  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   output logic [IdxW-1:0] idx
);

   localparam logic [IdxW-1:0] LastIdx = IdxW'(Lanes - 1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx <= '0;
      end else if (!enable) begin
         idx <= '0;
      end else if (idx == LastIdx) begin
         idx <= '0;
      end else begin
         idx <= idx + 1'b1;
      end
   end

endmodule

// File: rtl/mem_output_manager.sv
// MEM-path gather stage: packs consecutive memory words into a lane vector and
// carries the load's destination register alongside it.
module mem_output_manager
   import vec_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              enable_read,
   input  logic [REG_W-1:0]  RD_in,
   input  logic [DATA_W-1:0] input_data,
   output logic [REG_W-1:0]  RD_out,
   output vec_t              output_data
);

   logic [IDX_W-1:0] idx;
   vec_t             lanes_q;
   reg_idx_t         rd_q;

   lane_counter #(
      .Lanes (LANES),
      .IdxW  (IDX_W)
   ) u_lane_counter (
      .clk    (clk),
      .rst    (rst),
      .enable (enable_read),
      .idx    (idx)
   );

   // RD is sampled only on the first word of a burst; unwritten lanes keep old data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lanes_q <= '0;
         rd_q    <= '0;
      end else if (enable_read) begin
         lanes_q[idx] <= input_data;
         if (idx == '0) begin
            rd_q <= RD_in;
         end
      end
   end

   assign output_data = lanes_q;
   assign RD_out      = rd_q;

endmodule

// File: tb/tb_mem_output_manager.sv
// Self-checking bench for mem_output_manager against a burst-position reference model.
module tb_mem_output_manager;
   import vec_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              enable_read = 1'b0;
   logic [REG_W-1:0]  RD_in = '0;
   logic [DATA_W-1:0] input_data = '0;
   logic [REG_W-1:0]  RD_out;
   vec_t              output_data;

   int errors = 0;
   int checks = 0;

   // Reference model: words accepted so far in the current run of enabled cycles.
   logic [DATA_W-1:0] m_lane [LANES];
   logic [REG_W-1:0]  m_rd;
   int                m_pos;

   mem_output_manager dut (
      .clk         (clk),
      .rst         (rst),
      .enable_read (enable_read),
      .RD_in       (RD_in),
      .input_data  (input_data),
      .RD_out      (RD_out),
      .output_data (output_data)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < LANES; i++) m_lane[i] = '0;
      m_rd  = '0;
      m_pos = 0;
   endtask

   // Drive one cycle, let the edge pass, update the model, settle 1ns past the edge.
   task automatic step(input logic en, input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
      enable_read = en;
      RD_in       = rd;
      input_data  = d;
      @(posedge clk);
      if (en) begin
         if (m_pos == 0) m_rd = rd;
         m_lane[m_pos] = d;
         m_pos = (m_pos + 1) % LANES;
      end else begin
         m_pos = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 4; c++) begin
         enable_read = 1'($urandom);
         RD_in       = REG_W'($urandom);
         input_data  = DATA_W'($urandom);
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < LANES; i++) begin
         checks++;
         if (output_data[i] !== '0) begin
            errors++;
            $display("FAIL reset_hold lane%0d: got %h want 0000", i, output_data[i]);
         end
      end
      checks++;
      if (RD_out !== '0) begin
         errors++;
         $display("FAIL reset_hold rd: got %0d want 0", RD_out);
      end
      rst = 1'b1;
      for (int c = 0; c < 3; c++) step(1'b0, REG_W'($urandom), DATA_W'($urandom));
      checks++;
      if (output_data !== '0 || RD_out !== '0) begin
         errors++;
         $display("FAIL reset_release: got rd=%0d data=%h want all zero", RD_out, output_data);
      end
   endtask

   task automatic test_full_burst();
      for (int i = 0; i < LANES; i++) step(1'b1, 5'd2, DATA_W'(i + 1));
      for (int i = 0; i < LANES; i++) begin
         checks++;
         if (output_data[i] !== DATA_W'(i + 1)) begin
            errors++;
            $display("FAIL full_burst lane%0d: got %h want %h", i, output_data[i], DATA_W'(i + 1));
         end
      end
      checks++;
      if (RD_out !== 5'd2) begin
         errors++;
         $display("FAIL full_burst rd: got %0d want 2", RD_out);
      end
   endtask

   task automatic test_partial_abort();
      for (int i = 0; i < 5; i++) step(1'b1, 5'd7, 16'hA000 + DATA_W'(i));
      step(1'b0, 5'd7, 16'h0);
      step(1'b1, 5'd9, 16'hB000);
      step(1'b1, 5'd9, 16'hB001);
      for (int i = 0; i < LANES; i++) begin
         checks++;
         if (output_data[i] !== m_lane[i]) begin
            errors++;
            $display("FAIL partial_abort lane%0d: got %h want %h", i, output_data[i], m_lane[i]);
         end
      end
      checks++;
      if (output_data[2] !== 16'hA002 || output_data[4] !== 16'hA004 || RD_out !== 5'd9) begin
         errors++;
         $display("FAIL partial_abort fixed: got l2=%h l4=%h rd=%0d want A002 A004 9",
                  output_data[2], output_data[4], RD_out);
      end
      step(1'b0, 5'd0, 16'h0);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 16; i++) step(1'b1, 5'd3, DATA_W'(i));
      checks++;
      if (RD_out !== 5'd3) begin
         errors++;
         $display("FAIL wrap_first_rd: got %0d want 3", RD_out);
      end
      step(1'b1, 5'd4, 16'h0010);
      for (int i = 0; i < LANES; i++) begin
         checks++;
         if (output_data[i] !== ((i == 0) ? 16'h0010 : DATA_W'(i))) begin
            errors++;
            $display("FAIL wrap lane%0d: got %h want %h", i, output_data[i],
                     (i == 0) ? 16'h0010 : DATA_W'(i));
         end
      end
      checks++;
      if (RD_out !== 5'd4) begin
         errors++;
         $display("FAIL wrap rd: got %0d want 4", RD_out);
      end
      step(1'b0, 5'd0, 16'h0);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 5'd11, DATA_W'($urandom));
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      checks++;
      if (output_data !== '0 || RD_out !== '0) begin
         errors++;
         $display("FAIL async_reset: got rd=%0d data=%h want all zero", RD_out, output_data);
      end
      #1;
      rst = 1'b1;
      step(1'b1, 5'd6, 16'h5555);
      for (int i = 0; i < LANES; i++) begin
         checks++;
         if (output_data[i] !== ((i == 0) ? 16'h5555 : 16'h0000)) begin
            errors++;
            $display("FAIL async_release lane%0d: got %h want %h", i, output_data[i],
                     (i == 0) ? 16'h5555 : 16'h0000);
         end
      end
      checks++;
      if (RD_out !== 5'd6) begin
         errors++;
         $display("FAIL async_release rd: got %0d want 6", RD_out);
      end
   endtask

   task automatic test_hold();
      vec_t             snap_data;
      logic [REG_W-1:0] snap_rd;
      for (int i = 0; i < 5; i++) step(1'b1, 5'd12, DATA_W'($urandom));
      snap_data = output_data;
      snap_rd   = RD_out;
      for (int c = 0; c < 10; c++) begin
         step(1'b0, REG_W'($urandom), DATA_W'($urandom));
         checks++;
         if (output_data !== snap_data || RD_out !== snap_rd) begin
            errors++;
            $display("FAIL hold cycle%0d: got rd=%0d data=%h want rd=%0d data=%h",
                     c, RD_out, output_data, snap_rd, snap_data);
         end
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int c = 0; c < 300; c++) begin
         step(($urandom_range(0, 9) < 8), REG_W'($urandom), DATA_W'($urandom));
         for (int i = 0; i < LANES; i++) begin
            checks++;
            if (output_data[i] !== m_lane[i]) begin
               errors++;
               if (bad++ < 10)
                  $display("FAIL random c%0d lane%0d: got %h want %h", c, i, output_data[i],
                           m_lane[i]);
            end
         end
         checks++;
         if (RD_out !== m_rd) begin
            errors++;
            if (bad++ < 10) $display("FAIL random c%0d rd: got %0d want %0d", c, RD_out, m_rd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_burst();
      test_partial_abort();
      test_wrap();
      test_async_reset();
      test_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
